// File: rtl/status_response_tx_if.sv
// Byte-wide valid/accept link carrying status response frames toward the PC.
// The block drives data/ready (master); the link side returns the accept (slave).
interface status_response_tx_if #(
  parameter int TX_WIDTH = 8
) ();
  logic [TX_WIDTH-1:0] tx_data_o;
  logic                tx_rdy_o;
  logic                tx_ack_i;

  modport master (
    output tx_data_o,
    output tx_rdy_o,
    input  tx_ack_i
  );

  modport slave (
    input  tx_data_o,
    input  tx_rdy_o,
    output tx_ack_i
  );
endinterface

// File: rtl/status_response_tx.sv
// Sends a three-byte status response (HEADER, word MSB, word LSB) per request,
// collapsing requests that arrive mid-frame into a single back-to-back follow-up frame.
module status_response_tx #(
  parameter int                  REG_DATA_WIDTH = 16,
  parameter int                  TX_WIDTH       = 8,
  parameter logic [TX_WIDTH-1:0] HEADER         = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      soft_rst_i,
  input  logic                      rqst_i,
  input  logic [REG_DATA_WIDTH-1:0] status_i,
  status_response_tx_if.master      link,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    MSB  = 2'd2,
    LSB  = 2'd3
  } state_t;

  logic [1:0]                rst_sync_reg;
  logic                      rst_int;
  state_t                    state_reg;
  state_t                    state_next;
  logic                      pend_reg;
  logic                      pend_next;
  logic [REG_DATA_WIDTH-1:0] hold_reg;
  logic [REG_DATA_WIDTH-1:0] hold_next;
  logic                      done_reg;
  logic                      done_next;
  logic                      rdy;
  logic                      xfer;
  logic                      last_xfer;
  logic                      restart;

  // Reset asserts at once but releases only after two clean clk edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_reg <= 2'b11;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_reg[1];

  assign rdy       = (state_reg != IDLE);
  assign xfer      = rdy && link.tx_ack_i;
  assign last_xfer = (state_reg == LSB) && xfer;
  // A request seen on the final transfer cycle chains straight into a new frame.
  assign restart   = pend_reg || rqst_i;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_reg <= IDLE;
      pend_reg  <= 1'b0;
      hold_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      hold_reg  <= hold_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (soft_rst_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (rqst_i) state_next = HDR;
        HDR:  if (xfer)   state_next = MSB;
        MSB:  if (xfer)   state_next = LSB;
        LSB:  if (xfer)   state_next = restart ? HDR : IDLE;
        default:          state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_next = hold_reg;
    pend_next = pend_reg;
    done_next = 1'b0;
    if (soft_rst_i) begin
      pend_next = 1'b0;
    end else if (state_reg == IDLE) begin
      pend_next = 1'b0;
      if (rqst_i) hold_next = status_i;
    end else if (last_xfer) begin
      done_next = 1'b1;
      pend_next = 1'b0;
      if (restart) hold_next = status_i;
    end else begin
      pend_next = pend_reg || rqst_i;
    end
  end

  always_comb begin
    link.tx_data_o = '0;
    case (state_reg)
      HDR:     link.tx_data_o = HEADER;
      MSB:     link.tx_data_o = hold_reg[REG_DATA_WIDTH-1 -: TX_WIDTH];
      LSB:     link.tx_data_o = hold_reg[TX_WIDTH-1:0];
      default: link.tx_data_o = '0;
    endcase
    link.tx_rdy_o = rdy;
    busy_o        = rdy;
    done_o        = done_reg;
  end

endmodule

// File: tb/tb_status_response_tx.sv
// Randomised and directed checks of status_response_tx against a frame-level model
// (expected byte stream, busy/done timing) kept in the bench.
module tb_status_response_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst;
  logic        rqst;
  logic [15:0] status;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  bit          m_busy;
  int          m_idx;
  logic [15:0] m_word;
  bit          m_pend;
  bit          m_done;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          done_cnt;

  always #5 clk = ~clk;

  status_response_tx_if #(.TX_WIDTH(8)) link ();

  status_response_tx #(
    .REG_DATA_WIDTH(16),
    .TX_WIDTH      (8),
    .HEADER        (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst_i(soft_rst),
    .rqst_i    (rqst),
    .status_i  (status),
    .link      (link),
    .busy_o    (busy),
    .done_o    (done)
  );

  function automatic logic [7:0] m_byte();
    if (m_idx == 0) return 8'hA5;
    if (m_idx == 1) return m_word[15:8];
    return m_word[7:0];
  endfunction

  task automatic model_clear();
    m_busy = 0;
    m_idx  = 0;
    m_pend = 0;
    m_done = 0;
  endtask

  // Advance one clock: log transfers, step the model with the current inputs.
  task automatic tick();
    bit x;
    if (link.tx_rdy_o === 1'b1 && link.tx_ack_i === 1'b1) got_q.push_back(link.tx_data_o);
    x = m_busy && link.tx_ack_i;
    if (x) exp_q.push_back(m_byte());
    if (soft_rst) begin
      model_clear();
    end else begin
      m_done = x && (m_idx == 2);
      if (!m_busy) begin
        if (rqst) begin
          m_busy = 1; m_idx = 0; m_word = status;
        end
      end else if (x && m_idx == 2) begin
        if (m_pend || rqst) begin
          m_idx = 0; m_word = status;
        end else begin
          m_busy = 0;
        end
        m_pend = 0;
      end else begin
        if (x) m_idx++;
        m_pend = m_pend || rqst;
      end
    end
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic clear_logs();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_rst = 1'b0; rqst = 1'b0; status = 16'h0;
    link.tx_ack_i = 1'b0;
    model_clear();
    #2;
    checks++; if (link.tx_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", link.tx_rdy_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (link.tx_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", link.tx_data_o); end
    rqst = 1'b1; link.tx_ack_i = 1'b1; status = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || link.tx_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_hold_rqst: busy %b rdy %b want 0 0", busy, link.tx_rdy_o); end
    rqst = 1'b0; rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [7:0] e[3] = '{8'hA5, 8'h12, 8'h34};
    clear_logs();
    status = 16'h1234; rqst = 1'b1; link.tx_ack_i = 1'b1;
    tick();
    rqst = 1'b0; status = 16'($urandom);
    checks++; if (link.tx_rdy_o !== 1'b1 || link.tx_data_o !== 8'hA5) begin errors++; $display("FAIL basic_hdr: rdy %b data %h want 1 a5", link.tx_rdy_o, link.tx_data_o); end
    tick();
    checks++; if (link.tx_data_o !== 8'h12) begin errors++; $display("FAIL basic_msb: got %h want 12", link.tx_data_o); end
    tick();
    checks++; if (link.tx_data_o !== 8'h34) begin errors++; $display("FAIL basic_lsb: got %h want 34", link.tx_data_o); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: done %b busy %b want 1 0", done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: done %b want 0", done); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count: got %0d bytes want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== e[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got_q[i], e[i]); end
    end
    $display("test_basic done");
  endtask

  task automatic test_backpressure();
    logic [7:0] e[3] = '{8'hA5, 8'h12, 8'h34};
    clear_logs();
    status = 16'h1234; rqst = 1'b1; link.tx_ack_i = 1'b1;
    tick();
    rqst = 1'b0; status = 16'($urandom);
    tick();
    link.tx_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (link.tx_data_o !== 8'h12 || link.tx_rdy_o !== 1'b1) begin errors++; $display("FAIL bp_stall%0d: data %h rdy %b want 12 1", i, link.tx_data_o, link.tx_rdy_o); end
      status = 16'($urandom);
      tick();
    end
    checks++; if (link.tx_data_o !== 8'h12) begin errors++; $display("FAIL bp_after_stall: got %h want 12", link.tx_data_o); end
    link.tx_ack_i = 1'b1;
    repeat (3) tick();
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL bp_done: done pulses %0d busy %b want 1 0", done_cnt, busy); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d bytes want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== e[i]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got_q[i], e[i]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_collapse();
    logic [7:0] e[6] = '{8'hA5, 8'h12, 8'h34, 8'hA5, 8'hBE, 8'hEF};
    clear_logs();
    status = 16'h1234; rqst = 1'b1; link.tx_ack_i = 1'b1;
    tick();
    status = 16'h5555;
    rqst = 1'b1; link.tx_ack_i = 1'b0; tick();
    rqst = 1'b0; link.tx_ack_i = 1'b1; tick();
    rqst = 1'b1; link.tx_ack_i = 1'b0; tick();
    rqst = 1'b0; tick();
    rqst = 1'b1; tick();
    rqst = 1'b0; link.tx_ack_i = 1'b1; tick();
    status = 16'hBEEF;
    tick();
    status = 16'h0F0F;
    checks++; if (link.tx_rdy_o !== 1'b1 || link.tx_data_o !== 8'hA5 || done !== 1'b1) begin errors++; $display("FAIL collapse_chain: rdy %b data %h done %b want 1 a5 1", link.tx_rdy_o, link.tx_data_o, done); end
    repeat (5) tick();
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL collapse_done: got %0d pulses want 2", done_cnt); end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL collapse_count: got %0d bytes want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== e[i]) begin errors++; $display("FAIL collapse_byte%0d: got %h want %h", i, got_q[i], e[i]); end
    end
    $display("test_collapse done");
  endtask

  task automatic test_soft_abort();
    clear_logs();
    status = 16'($urandom); rqst = 1'b1; link.tx_ack_i = 1'b1;
    tick();
    rqst = 1'b0; tick();
    rqst = 1'b1; link.tx_ack_i = 1'b0; tick();
    rqst = 1'b1; soft_rst = 1'b1; tick();
    rqst = 1'b0; soft_rst = 1'b0; link.tx_ack_i = 1'b1;
    checks++; if (link.tx_rdy_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: rdy %b busy %b want 0 0", link.tx_rdy_o, busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (link.tx_rdy_o !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_quiet%0d: rdy %b done %b want 0 0", i, link.tx_rdy_o, done); end
    end
    checks++; if (got_q.size() != 1 || done_cnt != 0) begin errors++; $display("FAIL abort_bytes: got %0d bytes %0d done want 1 0", got_q.size(), done_cnt); end
    $display("test_soft_abort done");
  endtask

  task automatic test_async_reset();
    logic [7:0] e[3] = '{8'hA5, 8'h9A, 8'hBC};
    clear_logs();
    status = 16'h5678; rqst = 1'b1; link.tx_ack_i = 1'b0;
    tick();
    rqst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (link.tx_rdy_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_drop: rdy %b busy %b want 0 0", link.tx_rdy_o, busy); end
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; link.tx_ack_i = 1'b1;
    repeat (3) tick();
    clear_logs();
    status = 16'h9ABC; rqst = 1'b1;
    tick();
    rqst = 1'b0;
    repeat (4) tick();
    checks++; if (got_q.size() != 3 || done_cnt != 1) begin errors++; $display("FAIL async_frame: got %0d bytes %0d done want 3 1", got_q.size(), done_cnt); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== e[i]) begin errors++; $display("FAIL async_byte%0d: got %h want %h", i, got_q[i], e[i]); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_latch_isolation();
    logic [15:0] s0;
    s0 = 16'($urandom);
    status = s0; rqst = 1'b1; link.tx_ack_i = 1'b1;
    tick();
    rqst = 1'b0; status = ~s0;
    tick();
    status = 16'($urandom);
    checks++; if (link.tx_data_o !== s0[15:8]) begin errors++; $display("FAIL iso_msb: got %h want %h", link.tx_data_o, s0[15:8]); end
    tick();
    status = 16'($urandom);
    checks++; if (link.tx_data_o !== s0[7:0]) begin errors++; $display("FAIL iso_lsb: got %h want %h", link.tx_data_o, s0[7:0]); end
    repeat (2) tick();
    $display("test_latch_isolation done");
  endtask

  task automatic test_random();
    clear_logs();
    for (int n = 0; n < 600; n++) begin
      soft_rst      = ($urandom_range(0, 49) == 0);
      rqst          = ($urandom_range(0, 5) == 0);
      link.tx_ack_i = ($urandom_range(0, 3) != 0);
      status        = 16'($urandom);
      tick();
      checks++; if (link.tx_rdy_o !== m_busy) begin errors++; $display("FAIL rand_rdy @%0d: got %b want %b", n, link.tx_rdy_o, m_busy); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy @%0d: got %b want %b", n, busy, m_busy); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rand_done @%0d: got %b want %b", n, done, m_done); end
      checks++; if (link.tx_data_o !== (m_busy ? m_byte() : 8'h00)) begin errors++; $display("FAIL rand_data @%0d: got %h want %h", n, link.tx_data_o, (m_busy ? m_byte() : 8'h00)); end
    end
    soft_rst = 1'b0; rqst = 1'b0; link.tx_ack_i = 1'b1;
    repeat (8) tick();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_stream_len: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_stream%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    $display("test_random done: %0d bytes", got_q.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_collapse();
    test_soft_abort();
    test_async_reset();
    test_latch_isolation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_response_tx.md
STATUS_RESPONSE_TX -- requirements
Module: status_response_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- REG_DATA_WIDTH, 16, status word width; fixed at 16 in this revision.
- TX_WIDTH, 8, byte width of the transmit interface.
- HEADER, 8'hA5, first byte of every response frame.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, fpga clock; the block uses this single clock.
- rst, in, 1, asynchronous, active-high reset.
- soft_rst_i, in, 1, synchronous abort, driven by the request decoder's reset pulse.
- rqst_i, in, 1, single-cycle trigger-status request pulse.
- status_i, in, REG_DATA_WIDTH, live trigger status word.
- tx_data_o, out, TX_WIDTH, byte toward the PC link.
- tx_rdy_o, out, 1, tx_data_o valid.
- tx_ack_i, in, 1, link accepts the byte.
- busy_o, out, 1, frame in progress.
- done_o, out, 1, one-cycle pulse when a frame completes.

Function
REQ-003 The FSM SHALL have the states IDLE, HDR, MSB and LSB; busy_o SHALL be 1 in every state except IDLE.
REQ-004 A byte SHALL transfer on a rising clk edge where tx_rdy_o=1 and tx_ack_i=1.
REQ-005 tx_rdy_o SHALL be 1 in HDR, MSB and LSB, and 0 in IDLE.
REQ-006 tx_data_o SHALL hold stable while tx_rdy_o=1 and the byte has not transferred.
REQ-007 tx_data_o SHALL be HEADER in HDR, the latched word bits [15:8] in MSB, and the latched word bits [7:0] in LSB; in IDLE it SHALL be 0.
REQ-008 In IDLE, rqst_i=1 SHALL latch status_i into a holding register on the same edge and move to HDR, so tx_rdy_o rises one cycle after rqst_i.
REQ-009 The transitions HDR->MSB, MSB->LSB and LSB->IDLE SHALL occur only on a transfer; with tx_ack_i=0 the state SHALL be held indefinitely.
REQ-010 A transfer in LSB SHALL assert done_o for exactly the next cycle.
REQ-011 rqst_i=1 while busy_o=1, including the final LSB transfer cycle, SHALL set a pending flag; any number of such requests SHALL collapse into one pending flag.
REQ-012 The holding register SHALL NOT change while busy_o=1.
REQ-013 On the LSB transfer edge with the pending flag set:
- the FSM SHALL go to HDR instead of IDLE;
- status_i SHALL be re-latched on that same edge;
- the pending flag SHALL be cleared;
- done_o SHALL still pulse;
- tx_rdy_o SHALL stay 1 with no idle gap.
REQ-014 soft_rst_i=1 SHALL take priority over every other input. On the next edge:
- the state SHALL be IDLE;
- the pending flag SHALL be cleared;
- tx_rdy_o, busy_o and done_o SHALL be 0;
- rqst_i on that same cycle SHALL be ignored;
- any partially sent frame SHALL be abandoned, not resumed.
REQ-015 A transfer and soft_rst_i in the same cycle SHALL count as a consumed byte at the link; the block SHALL still go to IDLE.
REQ-016 Bytes SHALL be sent in the fixed order HEADER, MSB, LSB.
REQ-017 Each frame SHALL be exactly three transfers.

Reset
REQ-018 While rst=1, regardless of clk:
- the state SHALL be IDLE;
- the pending flag, the holding register, tx_data_o, tx_rdy_o, busy_o and done_o SHALL all be 0.
REQ-019 Deassertion of rst SHALL be synchronised to clk, so the first active edge is well defined.
REQ-020 Assertion of rst mid-frame SHALL drop tx_rdy_o immediately, with no completion of the byte.

Verification
REQ-021 Basic frame: status_i=16'h1234, rqst_i pulse, tx_ack_i held at 1 -> bytes A5, 12, 34 on three consecutive edges, then done_o for one cycle, then busy_o=0.
REQ-022 Backpressure: tx_ack_i=0 for 5 cycles in MSB -> tx_data_o=12 held stable for all 5 cycles; a later ack completes the frame unchanged.
REQ-023 Collapse: three rqst_i pulses during a frame, and status_i=16'hBEEF at the LSB transfer -> exactly one extra frame A5, BE, EF, back-to-back, with 2 done_o pulses in total.
REQ-024 Soft abort: soft_rst_i in MSB with a pending request -> IDLE and tx_rdy_o=0 the next cycle, no further bytes, no done_o.
REQ-025 Async reset: rst asserted mid-HDR between clock edges -> tx_rdy_o and busy_o fall without a clk edge; after release, the first rqst_i sends a full fresh frame.
REQ-026 Latch isolation: status_i changes every cycle during a frame -> the MSB and LSB bytes equal status_i as sampled on the rqst_i cycle.
